// File: rtl/pla_lut_pkg.sv
// pla_lut_pkg: shared types, default parameters and helpers for the PLA
// lookup-table engine.
// Optional build macro: PLA_LUT_PARITY_EN (parity storage and checking).
package pla_lut_pkg;

    // Engine control states: table clear after reset, then normal operation.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_IN_W  = 9;
    localparam int DEF_OUT_W = 6;
    localparam int DEF_CNT_W = 16;

    // Even parity bit: makes the total number of ones (data + bit) even.
    // Callers zero-extend their data to 32 bits.
    function automatic logic even_par(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pla_lut_mem.sv
// pla_lut_mem: 2^AW x DW register array, one synchronous write port and
// one combinational read port. A read of the address being written in the
// same cycle returns the old contents.
module pla_lut_mem
    import pla_lut_pkg::*;
#(
    parameter int AW = DEF_IN_W,
    parameter int DW = DEF_OUT_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Table write; contents are not reset, the engine clears them itself.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pla_lut_engine.sv
// pla_lut_engine: runtime-programmable registered truth table. After reset
// the table is cleared one entry per cycle, then lookups flow through a
// one-cycle valid/ready stage while the config port may rewrite entries.
// Optional build macro: PLA_LUT_PARITY_EN (per-entry parity bit, out_perr
// and err_sticky become live; otherwise they are tied low).
module pla_lut_engine
    import pla_lut_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_par_inv,
    output logic             cfg_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_z,
    output logic             out_perr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic             init_done,
    output logic [0:0]       state_dbg
);

`ifdef PLA_LUT_PARITY_EN
    localparam int MEM_W = OUT_W + 1;
`else
    localparam int MEM_W = OUT_W;
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A producer holds valid and its payload until that edge; ready may
    // depend combinationally on the consumer side (in_ready on out_ready).

    state_t          state, state_nxt;
    logic [IN_W-1:0] clr_ptr;
    logic            run;
    logic            accept;
    logic            take;

    logic             mem_we;
    logic [IN_W-1:0]  mem_waddr;
    logic [MEM_W-1:0] mem_wdata;
    logic [MEM_W-1:0] mem_rdata;

    assign run       = (state == ST_RUN);
    assign cfg_ready = run;
    assign in_ready  = run && (!out_valid || out_ready);
    assign init_done = run;
    assign state_dbg = state;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    // State register and clear pointer; the pointer only moves during INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Leave INIT once the last entry has been cleared.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && (&clr_ptr)) begin
            state_nxt = ST_RUN;
        end
    end

    // Table write port: clear writes during INIT, config writes during RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (cfg_we) begin
            mem_we    = 1'b1;
            mem_waddr = cfg_addr;
`ifdef PLA_LUT_PARITY_EN
            mem_wdata = {even_par(32'(cfg_data)) ^ cfg_par_inv, cfg_data};
`else
            mem_wdata = cfg_data;
`endif
        end
    end

    pla_lut_mem #(
        .AW(IN_W),
        .DW(MEM_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (in_x),
        .rdata (mem_rdata)
    );

    // Output stage: load on accept, drop valid after a handshake with no
    // new accept, hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_z     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_z     <= mem_rdata[OUT_W-1:0];
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

    // Completed-lookup counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt <= '0;
        end else if (take && !(&lookup_cnt)) begin
            lookup_cnt <= lookup_cnt + 1'b1;
        end
    end

`ifdef PLA_LUT_PARITY_EN
    logic rd_perr;
    assign rd_perr = mem_rdata[OUT_W] != even_par(32'(mem_rdata[OUT_W-1:0]));

    // Parity flag travels with the result; sticky error sets on the edge
    // that presents a bad result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_perr   <= 1'b0;
            err_sticky <= 1'b0;
        end else if (accept) begin
            out_perr <= rd_perr;
            if (rd_perr) begin
                err_sticky <= 1'b1;
            end
        end
    end
`else
    logic unused_par_inv;
    assign unused_par_inv = cfg_par_inv;
    assign out_perr       = 1'b0;
    assign err_sticky     = 1'b0;
`endif

endmodule
